// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Light-code constants, phase encoding and the light-to-phase
//            decoder shared by the traffic-light FSM and its timing block.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Per-direction light encoding driven by the traffic-light FSM
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b00;

  // Seconds counter saturates here
  localparam logic [7:0] SEC_CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    HW_GREEN    = 2'd0,
    HW_YELLOW   = 2'd1,
    LANE_GREEN  = 2'd2,
    LANE_YELLOW = 2'd3
  } phase_t;

  // Decoder result: legal=0 flags a light pair the FSM must never produce
  typedef struct packed {
    logic   legal;
    phase_t phase;
  } phase_dec_t;

  function automatic phase_dec_t decode_phase(input logic [1:0] hw_light,
                                              input logic [1:0] ln_light);
    phase_dec_t d;
    d.legal = 1'b1;
    d.phase = HW_GREEN;
    case ({hw_light, ln_light})
      {LIGHT_GREEN,  LIGHT_RED}:    d.phase = HW_GREEN;
      {LIGHT_YELLOW, LIGHT_RED}:    d.phase = HW_YELLOW;
      {LIGHT_RED,    LIGHT_GREEN}:  d.phase = LANE_GREEN;
      {LIGHT_RED,    LIGHT_YELLOW}: d.phase = LANE_YELLOW;
      default:                      d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : traffic_sensor_debounce
// Purpose  : Two-flop synchronizer followed by a stability counter. The
//            output follows the synchronized input only after it has held a
//            new value for DEBOUNCE_CYC consecutive cycles; any return to
//            the current output value restarts the count.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_sensor_debounce #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic db_out
);

  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_db;

  // Bring the asynchronous detector into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has been stable long enough
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync2 != r_db) begin
      if (r_cnt == c_cnt_last) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign db_out = r_db;

endmodule
`default_nettype wire

// File: rtl/traffic_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_timing_ctrl
// Purpose  : Timing and sensor conditioning for the highway/lane traffic
//            light FSM. Decodes the phase from the FSM lights, counts whole
//            seconds per phase, gates the debounced vehicle sensor by the
//            minimum highway green / maximum lane green, and produces the
//            one-cycle yellow-expiry pulse. Illegal light pairs latch fault.
// Options  : TRAFFIC_TIMING_STATS_EN - adds the 16-bit lane_serviced counter
//            (LANE_YELLOW -> HW_GREEN transitions, wrapping).
// Revision : 1.0 - initial release
// ============================================================================
module traffic_timing_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_PER_SEC    = 50_000_000,
  parameter int YELLOW_SEC     = 3,
  parameter int MIN_GREEN_HW   = 10,
  parameter int MAX_GREEN_LANE = 20,
  parameter int DEBOUNCE_CYC   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        raw_sensor,
  input  logic [1:0]  highway,
  input  logic [1:0]  lane,
  output logic        sensor,
  output logic        delay_3sec,
  output logic [1:0]  phase,
  output logic [7:0]  sec_cnt,
  output logic        fault
`ifdef TRAFFIC_TIMING_STATS_EN
  ,
  output logic [15:0] lane_serviced
`endif
);

  localparam int                   c_presc_w     = $clog2(CLK_PER_SEC);
  localparam logic [c_presc_w-1:0] c_presc_last  = c_presc_w'(CLK_PER_SEC - 1);
  localparam logic [c_presc_w-1:0] c_presc_one   = c_presc_w'(1);
  localparam logic [7:0]           c_yellow_last = 8'(YELLOW_SEC - 1);
  localparam logic [7:0]           c_min_green   = 8'(MIN_GREEN_HW);
  localparam logic [7:0]           c_max_lane    = 8'(MAX_GREEN_LANE);

  phase_dec_t           w_dec;
  logic                 w_phase_change;
  logic                 w_sec_tick;
  logic                 w_db;
  logic                 w_sensor_nxt;
  logic                 w_delay_nxt;

  phase_t               r_phase;
  logic                 r_fault;
  logic [c_presc_w-1:0] r_presc;
  logic [7:0]           r_sec_cnt;
  logic                 r_sensor;
  logic                 r_delay;

  traffic_sensor_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .raw_in (raw_sensor),
    .db_out (w_db)
  );

  assign w_dec          = decode_phase(highway, lane);
  assign w_phase_change = w_dec.legal && (w_dec.phase != r_phase);
  // A phase change wins over the tick so the new phase starts from zero
  assign w_sec_tick     = (r_presc == c_presc_last) && !w_phase_change;

  // Track the decoded phase; an illegal pair holds the phase and latches fault
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= HW_GREEN;
      r_fault <= 1'b0;
    end else if (w_dec.legal) begin
      r_phase <= w_dec.phase;
    end else begin
      r_fault <= 1'b1;
    end
  end

  // Prescaler and per-phase seconds counter, both restarted on a phase change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_sec_cnt <= '0;
    end else if (w_phase_change) begin
      r_presc   <= '0;
      r_sec_cnt <= '0;
    end else if (w_sec_tick) begin
      r_presc <= '0;
      if (r_sec_cnt != SEC_CNT_MAX) begin
        r_sec_cnt <= r_sec_cnt + 8'd1;
      end
    end else begin
      r_presc <= r_presc + c_presc_one;
    end
  end

  // Next sensor/delay values; both are quiet on faults and phase boundaries
  always_comb begin
    w_sensor_nxt = 1'b0;
    w_delay_nxt  = 1'b0;
    if (!r_fault && w_dec.legal && !w_phase_change) begin
      case (r_phase)
        HW_GREEN:    w_sensor_nxt = w_db && (r_sec_cnt >= c_min_green);
        LANE_GREEN:  w_sensor_nxt = w_db && (r_sec_cnt < c_max_lane);
        HW_YELLOW,
        LANE_YELLOW: w_delay_nxt  = w_sec_tick && (r_sec_cnt == c_yellow_last);
      endcase
    end
  end

  // Register the FSM-facing outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sensor <= 1'b0;
      r_delay  <= 1'b0;
    end else begin
      r_sensor <= w_sensor_nxt;
      r_delay  <= w_delay_nxt;
    end
  end

`ifdef TRAFFIC_TIMING_STATS_EN
  logic [15:0] r_lane_serviced;

  // Count completed lane service cycles (lane yellow handing back to highway)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane_serviced <= '0;
    end else if (w_dec.legal && (r_phase == LANE_YELLOW) && (w_dec.phase == HW_GREEN)) begin
      r_lane_serviced <= r_lane_serviced + 16'd1;
    end
  end

  assign lane_serviced = r_lane_serviced;
`endif

  assign sensor     = r_sensor;
  assign delay_3sec = r_delay;
  assign phase      = r_phase;
  assign sec_cnt    = r_sec_cnt;
  assign fault      = r_fault;

endmodule
`default_nettype wire

// File: doc/traffic_timing_ctrl.md
Name: traffic_timing_ctrl

Overview:
Timing and sensor-conditioning controller for the highway/lane traffic-light FSM. Conditions the raw vehicle sensor and supplies the FSM's `sensor` and `delay_3sec` inputs. Decodes the current phase from the FSM's light outputs. Enforces minimum highway green, maximum lane green and yellow duration, all counted in seconds from a clock prescaler.

Parameters:
- CLK_PER_SEC, 50_000_000: clk cycles per second; must be ≥2.
- YELLOW_SEC, 3: yellow duration in seconds; 1..255.
- MIN_GREEN_HW, 10: minimum highway green seconds before the sensor is forwarded; 0..255.
- MAX_GREEN_LANE, 20: lane green seconds after which the sensor is forced low; 1..255.
- DEBOUNCE_CYC, 1000: cycles the synchronized raw sensor must be stable before the debounced value changes; ≥1.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high.
- raw_sensor, input, 1: asynchronous vehicle detector.
- highway, input, 2: FSM highway light (10 green, 01 yellow, 00 red).
- lane, input, 2: FSM lane light, same encoding.
- sensor, output, 1: conditioned sensor to the FSM.
- delay_3sec, output, 1: one-cycle yellow-expiry pulse to the FSM.
- phase, output, 2: decoded phase (0 HW_GREEN, 1 HW_YELLOW, 2 LANE_GREEN, 3 LANE_YELLOW).
- sec_cnt, output, 8: whole seconds elapsed in the current phase; saturates at 255.
- fault, output, 1: illegal light combination detected.

Behaviour:
- Reset values: sensor=0, delay_3sec=0, phase=0, sec_cnt=0, fault=0. Prescaler=0, debounced value=0, sync flops=0.
- Phase decode (combinational from lights):
  - {10,00} → HW_GREEN; {01,00} → HW_YELLOW; {00,10} → LANE_GREEN; {00,01} → LANE_YELLOW.
  - Any other combination is illegal.
- phase register:
  - Loads the decoded phase each cycle.
  - On an illegal combination it holds its value and fault is set to 1 on the next edge.
  - fault is sticky until reset.
  - While fault=1, sensor=0 and delay_3sec=0.
- Phase change (decoded ≠ phase register, legal): prescaler and sec_cnt clear on that edge, so the new phase starts at sec_cnt=0 and prescaler=0.
- Prescaler:
  - Counts 0..CLK_PER_SEC-1.
  - sec_tick is asserted when prescaler = CLK_PER_SEC-1 and no phase change occurs that cycle.
  - On sec_tick, sec_cnt increments, saturating at 255.
- Sensor conditioning:
  - Two-flop synchronizer feeds a stability counter.
  - The debounced value takes the synchronized value once it has differed from the current debounced value for DEBOUNCE_CYC consecutive cycles.
  - Any glitch restarts the count.
  - Latency from a clean raw edge to a debounced change: 2+DEBOUNCE_CYC cycles.
- sensor output (registered, one further cycle):
  - HW_GREEN: debounced AND sec_cnt ≥ MIN_GREEN_HW.
  - LANE_GREEN: debounced AND sec_cnt < MAX_GREEN_LANE. It is forced low at the max to end lane green.
  - Yellow phases: 0.
- delay_3sec (registered):
  - Pulses for exactly one cycle in a yellow phase, on the edge after the sec_tick that brings sec_cnt to YELLOW_SEC.
  - The pulse is not repeated within the same phase; once sec_cnt has passed YELLOW_SEC, no further pulse occurs in that phase.
  - It is never high in a green phase.
- Reset mid-phase: all timing restarts from zero, and the phase is re-decoded from the lights on the first edge after reset.

Optional Feature:
TRAFFIC_TIMING_STATS_EN
- Defined: adds output port `lane_serviced` (16 bits). It increments, wrapping, on each LANE_YELLOW→HW_GREEN transition and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package traffic_pkg:
  - Light-code constants (LIGHT_GREEN=2'b10, LIGHT_YELLOW=2'b01, LIGHT_RED=2'b00).
  - phase_t enum (HW_GREEN, HW_YELLOW, LANE_GREEN, LANE_YELLOW).
  - Phase-decode function shared with the light FSM.
- Sub-module traffic_sensor_debounce: synchronizer plus stability counter, parameter DEBOUNCE_CYC, ports clk/reset/raw_in/db_out.

Test Plan:
All scenarios use CLK_PER_SEC=4, YELLOW_SEC=3, MIN_GREEN_HW=2, MAX_GREEN_LANE=5, DEBOUNCE_CYC=3.
1. Lights {10,00}, raw_sensor=1 from cycle 0 → debounced high at cycle 5; sensor stays 0 until sec_cnt=2 (cycle 8), then sensor=1 one cycle later.
2. raw_sensor pulsed high for 2 cycles only → debounced value and sensor never rise.
3. Lights switch to {01,00} → sec_cnt=0 next edge; exactly one delay_3sec pulse 12 cycles later (sec_cnt=3); none afterwards even if lights are held.
4. Lights {00,10} with raw_sensor held 1 → sensor=1 until sec_cnt reaches 5, then sensor=0 (forced end of lane green).
5. Lights {10,10} for one cycle → fault=1 next edge; sensor and delay_3sec stay 0 thereafter; reset clears fault to 0.
6. reset asserted mid-yellow at sec_cnt=2 → all outputs 0 immediately; after release the full 3 s yellow restarts, and the delay pulse arrives 12 cycles after the first edge.
